// File: rtl/scmp_useq.sv
// Micro-PC sequencer for the SC/MP core: selects the next microcode ROM address
// from the control field, opcode dispatch, DLY countdown, halt and interrupt conditions.
module scmp_useq #(
    parameter int unsigned UADDR_W    = 8,
    parameter int unsigned DLY_W      = 18,
    parameter int unsigned RESET_ADDR = 0,
    parameter int unsigned FETCH_ADDR = 1,
    parameter int unsigned INT_ADDR   = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [1:0]         uc_ctl,
    input  logic [UADDR_W-1:0] uc_next,
    input  logic               uc_cond_en,
    input  logic               cond,
    input  logic               uc_mem,
    input  logic               mem_ack,
    input  logic               uc_halt,
    input  logic               cont,
    input  logic [UADDR_W-1:0] op_pc,
    input  logic               op_dly,
    input  logic [DLY_W-1:0]   dly_load,
    input  logic               irq,
    input  logic               ie,
    output logic [UADDR_W-1:0] upc,
    output logic               dly_busy,
    output logic               halted,
    output logic               int_ack,
    output logic [1:0]         dbg_state
);

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_DELAY  = 2'd1,
        ST_HALTED = 2'd2
    } state_t;

    localparam logic [1:0] CTL_SEQ    = 2'b00;
    localparam logic [1:0] CTL_JUMP   = 2'b01;
    localparam logic [1:0] CTL_DECODE = 2'b10;
    localparam logic [1:0] CTL_FETCH  = 2'b11;

    localparam logic [UADDR_W-1:0] RESET_UPC = UADDR_W'(RESET_ADDR);
    localparam logic [UADDR_W-1:0] FETCH_UPC = UADDR_W'(FETCH_ADDR);
    localparam logic [UADDR_W-1:0] INT_UPC   = UADDR_W'(INT_ADDR);

    state_t             state_q, state_d;
    logic [UADDR_W-1:0] upc_q, upc_d;
    logic [DLY_W-1:0]   cnt_q, cnt_d;
    logic               int_ack_q, int_ack_d;
    logic               dly_busy_q, halted_q;
    logic [UADDR_W-1:0] upc_inc;

    // Natural wrap at UADDR_W bits gives the modulo increment.
    assign upc_inc = upc_q + UADDR_W'(1);

    always_comb begin
        state_d   = state_q;
        upc_d     = upc_q;
        cnt_d     = cnt_q;
        int_ack_d = 1'b0;
        unique case (state_q)
            ST_RUN: begin
                if (uc_mem && !mem_ack) begin
                    // Bus stall: everything holds until the cycle completes.
                    upc_d = upc_q;
                end else if (uc_halt) begin
                    state_d = ST_HALTED;
                end else begin
                    unique case (uc_ctl)
                        CTL_SEQ:  upc_d = upc_inc;
                        CTL_JUMP: upc_d = (uc_cond_en && !cond) ? upc_inc : uc_next;
                        CTL_DECODE: begin
                            upc_d = op_pc;
                            if (op_dly) begin
                                cnt_d   = dly_load;
                                state_d = ST_DELAY;
                            end
                        end
                        CTL_FETCH: begin
                            if (irq && ie) begin
                                upc_d     = INT_UPC;
                                int_ack_d = 1'b1;
                            end else begin
                                upc_d = FETCH_UPC;
                            end
                        end
                        default: upc_d = upc_q;
                    endcase
                end
            end
            ST_DELAY: begin
                // upc stays at the DLY entry so that word runs once the count expires.
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - DLY_W'(1);
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_HALTED: begin
                if (cont) begin
                    state_d = ST_RUN;
                    upc_d   = upc_inc;
                end
            end
            default: state_d = ST_RUN;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_RUN;
            upc_q      <= RESET_UPC;
            cnt_q      <= '0;
            int_ack_q  <= 1'b0;
            dly_busy_q <= 1'b0;
            halted_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            upc_q      <= upc_d;
            cnt_q      <= cnt_d;
            int_ack_q  <= int_ack_d;
            dly_busy_q <= (state_d == ST_DELAY);
            halted_q   <= (state_d == ST_HALTED);
        end
    end

    assign upc       = upc_q;
    assign dly_busy  = dly_busy_q;
    assign halted    = halted_q;
    assign int_ack   = int_ack_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_scmp_useq.sv
// Bench for scmp_useq: directed scenarios plus random traffic, checked cycle by
// cycle against a behavioural model of the sequencer.
module tb_scmp_useq;

    logic        clk;
    logic        rst_n;
    logic [1:0]  uc_ctl;
    logic [7:0]  uc_next;
    logic        uc_cond_en;
    logic        cond;
    logic        uc_mem;
    logic        mem_ack;
    logic        uc_halt;
    logic        cont;
    logic [7:0]  op_pc;
    logic        op_dly;
    logic [17:0] dly_load;
    logic        irq;
    logic        ie;
    logic [7:0]  upc;
    logic        dly_busy;
    logic        halted;
    logic        int_ack;
    logic [1:0]  dbg_state;

    int n_total = 0;
    int n_pass  = 0;

    // Model: mode 0 = running, 1 = delaying, 2 = halted; rem = busy cycles left.
    int m_upc, m_mode, m_rem, m_ack;

    scmp_useq dut (
        .clk(clk), .rst_n(rst_n), .uc_ctl(uc_ctl), .uc_next(uc_next),
        .uc_cond_en(uc_cond_en), .cond(cond), .uc_mem(uc_mem), .mem_ack(mem_ack),
        .uc_halt(uc_halt), .cont(cont), .op_pc(op_pc), .op_dly(op_dly),
        .dly_load(dly_load), .irq(irq), .ie(ie), .upc(upc), .dly_busy(dly_busy),
        .halted(halted), .int_ack(int_ack), .dbg_state(dbg_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        assert (got === exp) n_pass++;
        else $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    endtask

    task automatic chk_all(input string tag);
        chk({tag, ".upc"},      32'(upc),      32'(m_upc));
        chk({tag, ".dly_busy"}, 32'(dly_busy), 32'(m_mode == 1));
        chk({tag, ".halted"},   32'(halted),   32'(m_mode == 2));
        chk({tag, ".int_ack"},  32'(int_ack),  32'(m_ack));
    endtask

    task automatic idle();
        uc_ctl = 2'd0; uc_next = 8'h00; uc_cond_en = 1'b0; cond = 1'b0;
        uc_mem = 1'b0; mem_ack = 1'b0; uc_halt = 1'b0; cont = 1'b0;
        op_pc = 8'h00; op_dly = 1'b0; dly_load = 18'd0; irq = 1'b0; ie = 1'b0;
    endtask

    task automatic model_reset();
        m_upc = 0; m_mode = 0; m_rem = 0; m_ack = 0;
    endtask

    task automatic model_step();
        m_ack = 0;
        if (m_mode == 0) begin
            if (uc_mem && !mem_ack) begin
                m_upc = m_upc;
            end else if (uc_halt) begin
                m_mode = 2;
            end else if (uc_ctl == 2'd0) begin
                m_upc = (m_upc + 1) % 256;
            end else if (uc_ctl == 2'd1) begin
                m_upc = (uc_cond_en && !cond) ? (m_upc + 1) % 256 : int'(uc_next);
            end else if (uc_ctl == 2'd2) begin
                m_upc = int'(op_pc);
                if (op_dly) begin
                    m_mode = 1;
                    m_rem  = int'(dly_load) + 1;
                end
            end else begin
                if (irq && ie) begin
                    m_upc = 2;
                    m_ack = 1;
                end else begin
                    m_upc = 1;
                end
            end
        end else if (m_mode == 1) begin
            m_rem = m_rem - 1;
            if (m_rem == 0) m_mode = 0;
        end else begin
            if (cont) begin
                m_mode = 0;
                m_upc  = (m_upc + 1) % 256;
            end
        end
    endtask

    task automatic cycle(input string tag);
        model_step();
        @(posedge clk);
        #1;
        chk_all(tag);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        model_reset();
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        chk_all("reset");
    endtask

    initial begin
        idle();
        rst_n = 1'b0;
        model_reset();

        // SEQ across the 8-bit wrap
        do_reset();
        for (int i = 0; i < 260; i++) cycle("seq");
        chk("seq_wrap", 32'(upc), 32'd4);

        // Conditional JUMP
        do_reset();
        for (int i = 0; i < 5; i++) cycle("seq5");
        uc_ctl = 2'd1; uc_next = 8'h40; uc_cond_en = 1'b1; cond = 1'b0;
        cycle("jump_nc");
        chk("jump_nc_val", 32'(upc), 32'h06);
        cond = 1'b1;
        cycle("jump_c");
        chk("jump_c_val", 32'(upc), 32'h40);

        // DECODE into DLY, N=5 then N=0; ignored inputs during DELAY
        idle();
        uc_ctl = 2'd2; op_pc = 8'h30; op_dly = 1'b1; dly_load = 18'd5;
        cycle("dly5_entry");
        uc_halt = 1'b1; irq = 1'b1; ie = 1'b1; uc_ctl = 2'd3; op_pc = 8'h55;
        for (int i = 0; i < 5; i++) cycle("dly5_busy");
        chk("dly5_last_busy", 32'(dly_busy), 32'd1);
        cycle("dly5_exit");
        chk("dly5_exit_val", 32'(dly_busy), 32'd0);
        chk("dly5_exit_upc", 32'(upc), 32'h30);
        idle();
        uc_ctl = 2'd2; op_pc = 8'h30; op_dly = 1'b1; dly_load = 18'd0;
        cycle("dly0_entry");
        idle();
        cycle("dly0_exit");
        chk("dly0_exit_val", 32'(dly_busy), 32'd0);

        // FETCH with and without interrupt
        uc_ctl = 2'd3; irq = 1'b1; ie = 1'b1;
        cycle("fetch_int");
        chk("fetch_int_ack", 32'(int_ack), 32'd1);
        idle();
        cycle("fetch_int_after");
        uc_ctl = 2'd3; irq = 1'b1; ie = 1'b0;
        cycle("fetch_noint");
        chk("fetch_noint_upc", 32'(upc), 32'h01);

        // Memory stall at 0x12
        idle();
        uc_ctl = 2'd1; uc_next = 8'h12;
        cycle("goto12");
        uc_ctl = 2'd0; uc_mem = 1'b1; mem_ack = 1'b0; uc_halt = 1'b1;
        for (int i = 0; i < 3; i++) cycle("stall");
        chk("stall_upc", 32'(upc), 32'h12);
        uc_halt = 1'b0; mem_ack = 1'b1;
        cycle("stall_release");
        chk("stall_release_upc", 32'(upc), 32'h13);

        // HALT at 0x20, irq ignored, cont resumes
        idle();
        uc_ctl = 2'd1; uc_next = 8'h20;
        cycle("goto20");
        uc_halt = 1'b1;
        cycle("halt_entry");
        uc_halt = 1'b0; uc_ctl = 2'd3; irq = 1'b1; ie = 1'b1;
        for (int i = 0; i < 3; i++) cycle("halt_hold");
        idle();
        cont = 1'b1;
        cycle("halt_cont");
        chk("halt_cont_upc", 32'(upc), 32'h21);
        idle();

        // Async reset in the middle of a delay
        uc_ctl = 2'd2; op_pc = 8'h44; op_dly = 1'b1; dly_load = 18'd10;
        cycle("dly10_entry");
        idle();
        for (int i = 0; i < 3; i++) cycle("dly10_busy");
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        chk("rst_mid_upc", 32'(upc), 32'h00);
        chk("rst_mid_busy", 32'(dly_busy), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        chk_all("rst_mid_after");

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            uc_ctl     = 2'($urandom_range(0, 3));
            uc_next    = 8'($urandom);
            uc_cond_en = 1'($urandom);
            cond       = 1'($urandom);
            uc_mem     = ($urandom_range(0, 3) == 0);
            mem_ack    = 1'($urandom);
            uc_halt    = ($urandom_range(0, 15) == 0);
            cont       = ($urandom_range(0, 3) == 0);
            op_pc      = 8'($urandom);
            op_dly     = 1'($urandom);
            dly_load   = 18'($urandom_range(0, 6));
            irq        = 1'($urandom);
            ie         = 1'($urandom);
            cycle("rand");
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
